// File: rtl/shield_pkg.sv
// Shared types and constants for the shield bank: coordinates, health width and FSM states.
package shield_pkg;

    localparam int COORD_W       = 11;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef logic signed [COORD_W-1:0] coord_t;
    // One extra bit so edge arithmetic never wraps.
    typedef logic signed [COORD_W:0]   coord_ext_t;

    function automatic int health_w(input int max_health);
        return (max_health < 1) ? 1 : $clog2(max_health + 1);
    endfunction

    localparam int HEALTH_W = health_w(4);
    typedef logic [HEALTH_W-1:0] health_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } shield_state_t;

endpackage

// File: rtl/shield_hit_decoder.sv
// Maps a colliding pixel X to the shield whose hit span contains it (one-hot, or all zero).
module shield_hit_decoder
    import shield_pkg::*;
#(
    parameter int NUM_SHIELDS  = 4,
    parameter int SHIELD_WIDTH = 64
) (
    input  logic                                collision,
    input  logic signed [COORD_W-1:0]           collisionX,
    input  logic [NUM_SHIELDS-1:0][COORD_W-1:0] positions,
    output logic [NUM_SHIELDS-1:0]              hitVec
);

    localparam coord_ext_t SPAN = coord_ext_t'(SHIELD_WIDTH);

    coord_ext_t x_ext;
    assign x_ext = {collisionX[COORD_W-1], collisionX};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SHIELDS; gi++) begin : g_cmp
            coord_ext_t left_edge;
            coord_ext_t right_edge;
            assign left_edge  = {positions[gi][COORD_W-1], positions[gi]};
            assign right_edge = left_edge + SPAN;
            assign hitVec[gi] = collision && (x_ext >= left_edge) && (x_ext < right_edge);
        end
    endgenerate

endmodule

// File: rtl/shield_bank.sv
// Row of destructible shields: fixed placement, per-frame hit debounce, health tracking
// and optional periodic regeneration of damaged (but not destroyed) shields.
module shield_bank
    import shield_pkg::*;
#(
    parameter int NUM_SHIELDS  = 4,
    parameter int INITIAL_X    = 32,
    parameter int INITIAL_Y    = 400,
    parameter int SPACING      = 160,
    parameter int SHIELD_WIDTH = 64,
    parameter int MAX_HEALTH   = 4,
    parameter int REGEN_FRAMES = 0
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               startOfFrame,
    input  logic                                               playGame,
    input  logic                                               collision,
    input  logic signed [COORD_W-1:0]                          collisionX,
    output logic [NUM_SHIELDS-1:0][COORD_W-1:0]                topLeftX,
    output logic signed [COORD_W-1:0]                          topLeftY,
    output logic [NUM_SHIELDS-1:0][health_w(MAX_HEALTH)-1:0]   health,
    output logic [NUM_SHIELDS-1:0]                             alive,
    output logic                                               allDestroyed,
    output logic                                               hitPulse
);

    localparam int             HW        = health_w(MAX_HEALTH);
    localparam logic [HW-1:0]  FULL      = HW'(MAX_HEALTH);
    localparam logic [HW-1:0]  ONE       = HW'(1);
    localparam int             CW        = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'((REGEN_FRAMES > 0) ? REGEN_FRAMES - 1 : 0);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam bit             REGEN_ON  = (REGEN_FRAMES > 0);

    shield_state_t                  state;
    logic [NUM_SHIELDS-1:0]         pending;
    logic [CW-1:0]                  frame_cnt;
    logic [NUM_SHIELDS-1:0]         hit_vec;
    logic [NUM_SHIELDS-1:0]         hit_live;
    logic [NUM_SHIELDS-1:0]         dec_mask;
    logic                           regen_tick;
    logic [CW-1:0]                  frame_cnt_next;
    logic [NUM_SHIELDS-1:0][HW-1:0] health_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SHIELDS; gi++) begin : g_shield
            assign topLeftX[gi] = COORD_W'(INITIAL_X + gi * SPACING);
            assign alive[gi]    = |health[gi];
        end
    endgenerate

    assign topLeftY     = COORD_W'(INITIAL_Y);
    assign allDestroyed = ~|alive;

    shield_hit_decoder #(
        .NUM_SHIELDS  (NUM_SHIELDS),
        .SHIELD_WIDTH (SHIELD_WIDTH)
    ) u_decoder (
        .collision  (collision),
        .collisionX (collisionX),
        .positions  (topLeftX),
        .hitVec     (hit_vec)
    );

    // Destroyed shields neither latch new hits nor decrement further.
    assign hit_live   = hit_vec & alive;
    assign dec_mask   = pending & alive;
    assign regen_tick = REGEN_ON && (frame_cnt == CNT_LAST);

    always_comb begin
        frame_cnt_next = (!REGEN_ON || regen_tick) ? '0 : frame_cnt + CNT_ONE;
        health_next    = health;
        for (int i = 0; i < NUM_SHIELDS; i++) begin
            if (dec_mask[i]) begin
                health_next[i] = health[i] - ONE;
            end else if (regen_tick && alive[i] && (health[i] != FULL)) begin
                health_next[i] = health[i] + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            health    <= {NUM_SHIELDS{FULL}};
            pending   <= '0;
            frame_cnt <= '0;
            hitPulse  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    health    <= {NUM_SHIELDS{FULL}};
                    pending   <= '0;
                    frame_cnt <= '0;
                    hitPulse  <= 1'b0;
                    if (playGame) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!playGame) begin
                        // Leaving the game discards everything, even uncommitted hits.
                        state     <= IDLE;
                        health    <= {NUM_SHIELDS{FULL}};
                        pending   <= '0;
                        frame_cnt <= '0;
                        hitPulse  <= 1'b0;
                    end else if (startOfFrame) begin
                        health    <= health_next;
                        pending   <= hit_live;
                        frame_cnt <= frame_cnt_next;
                        hitPulse  <= |dec_mask;
                    end else begin
                        pending   <= pending | hit_live;
                        hitPulse  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shield_bank.sv
// Randomized and directed bench for shield_bank; two instances (no regen / regen every 2 frames)
// share stimulus and are checked every cycle against a frame-level reference model.
module tb_shield_bank;

    localparam int N    = 4;
    localparam int IX   = 32;
    localparam int IY   = 400;
    localparam int SP   = 160;
    localparam int W    = 64;
    localparam int MAXH = 4;
    localparam int NOHIT = -5000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sof = 1'b0;
    logic play = 1'b0;
    logic coll = 1'b0;
    logic signed [10:0] cx = '0;

    logic [N-1:0][10:0] tlx_a, tlx_b;
    logic signed [10:0] tly_a, tly_b;
    logic [N-1:0][2:0]  health_a, health_b;
    logic [N-1:0]       alive_a, alive_b;
    logic               alld_a, alld_b, pulse_a, pulse_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shield_bank u_dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .playGame(play),
        .collision(coll), .collisionX(cx), .topLeftX(tlx_a), .topLeftY(tly_a),
        .health(health_a), .alive(alive_a), .allDestroyed(alld_a), .hitPulse(pulse_a)
    );

    shield_bank #(.REGEN_FRAMES(2)) u_regen (
        .clk(clk), .reset(reset), .startOfFrame(sof), .playGame(play),
        .collision(coll), .collisionX(cx), .topLeftX(tlx_b), .topLeftY(tly_b),
        .health(health_b), .alive(alive_b), .allDestroyed(alld_b), .hitPulse(pulse_b)
    );

    typedef struct {
        logic [11:0] ha;
        logic [11:0] hb;
        logic        pa;
        logic        pb;
    } exp_t;

    exp_t q[$];

    // Reference model state: [0] = no regen, [1] = regen every 2nd commit.
    int mh[2][N];
    bit mpend[2][N];
    int ncommit[2];
    bit mpulse[2];
    bit run;
    int rf[2] = '{0, 2};

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int decode(bit c, int x);
        int off;
        if (!c || x < IX) return -1;
        off = x - IX;
        if ((off / SP) < N && (off % SP) < W) return off / SP;
        return -1;
    endfunction

    function automatic void restore(int m);
        for (int i = 0; i < N; i++) begin
            mh[m][i] = MAXH;
            mpend[m][i] = 1'b0;
        end
        ncommit[m] = 0;
        mpulse[m] = 1'b0;
    endfunction

    function automatic void model_step(bit s, bit p, bit c, int x);
        int hit;
        hit = decode(c, x);
        for (int m = 0; m < 2; m++) begin
            if (!run || !p) begin
                restore(m);
            end else begin
                bit hit_ok;
                bit regen;
                hit_ok = (hit >= 0) && (mh[m][hit] > 0);
                mpulse[m] = 1'b0;
                if (s) begin
                    ncommit[m]++;
                    regen = (rf[m] > 0) && (ncommit[m] % rf[m] == 0);
                    for (int i = 0; i < N; i++) begin
                        if (mpend[m][i] && mh[m][i] > 0) begin
                            mh[m][i]--;
                            mpulse[m] = 1'b1;
                        end else if (regen && mh[m][i] > 0 && mh[m][i] < MAXH) begin
                            mh[m][i]++;
                        end
                        mpend[m][i] = 1'b0;
                    end
                end
                if (hit_ok) mpend[m][hit] = 1'b1;
            end
        end
        run = p;
    endfunction

    function automatic logic [11:0] pack(int m);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*3 +: 3] = 3'(mh[m][i]);
        return r;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.ha = pack(0);
        e.hb = pack(1);
        e.pa = mpulse[0];
        e.pb = mpulse[1];
        return e;
    endfunction

    function automatic logic [3:0] exp_alive(logic [11:0] h);
        logic [3:0] a;
        for (int i = 0; i < N; i++) a[i] = (h[i*3 +: 3] != 3'd0);
        return a;
    endfunction

    task automatic cyc(bit s, bit p, bit c, int x);
        @(negedge clk);
        #2;
        reset = 1'b0;
        sof = s;
        play = p;
        coll = c;
        cx = 11'(x);
        model_step(s, p, c, x);
        q.push_back(snapshot());
    endtask

    task automatic frame(int len, int x);
        cyc(1'b1, 1'b1, 1'b0, 0);
        for (int k = 1; k < len; k++) cyc(1'b0, 1'b1, x != NOHIT, x);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_health_a", 32'(health_a), 32'h924);
        chk("async_reset_health_b", 32'(health_b), 32'h924);
        chk("async_reset_pulse_a", 32'(pulse_a), 32'd0);
        run = 1'b0;
        restore(0);
        restore(1);
        q.push_back(snapshot());
    endtask

    // Monitor: one expectation per clock edge, compared shortly after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("cycle t=%0t health_a=%h health_b=%h pulse_a=%0b pulse_b=%0b", $time,
                         health_a, health_b, pulse_a, pulse_b);
                chk("health_a", 32'(health_a), 32'(e.ha));
                chk("health_b", 32'(health_b), 32'(e.hb));
                chk("hitPulse_a", 32'(pulse_a), 32'(e.pa));
                chk("hitPulse_b", 32'(pulse_b), 32'(e.pb));
                chk("alive_a", 32'(alive_a), 32'(exp_alive(e.ha)));
                chk("alive_b", 32'(alive_b), 32'(exp_alive(e.hb)));
                chk("allDestroyed_a", 32'(alld_a), 32'(exp_alive(e.ha) == 4'd0));
                chk("allDestroyed_b", 32'(alld_b), 32'(exp_alive(e.hb) == 4'd0));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_health_a", 32'(health_a), 32'h924);
        chk("reset_pulse_a", 32'(pulse_a), 32'd0);
        chk("reset_alive_a", 32'(alive_a), 32'hF);
        chk("reset_allDestroyed_a", 32'(alld_a), 32'd0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("topLeftX_a[%0d]", i), 32'($signed(tlx_a[i])), 32'(IX + i * SP));
            chk($sformatf("topLeftX_b[%0d]", i), 32'($signed(tlx_b[i])), 32'(IX + i * SP));
        end
        chk("topLeftY_a", 32'($signed(tly_a)), 32'(IY));
        chk("topLeftY_b", 32'($signed(tly_b)), 32'(IY));

        run = 1'b0;
        restore(0);
        restore(1);

        // Enter the game and run clean frames.
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 0);
        repeat (3) frame(8, NOHIT);
        // Long burst on shield 1 commits once.
        frame(41, 200);
        // Edge, gap and off-row collisions: only X=95 hits (shield 0).
        cyc(1'b1, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 95);
        cyc(1'b0, 1'b1, 1'b1, 96);
        cyc(1'b0, 1'b1, 1'b1, -5);
        cyc(1'b0, 1'b1, 1'b1, 600);
        cyc(1'b0, 1'b1, 1'b0, 0);
        // Drive shield 0 to zero, then keep hitting it.
        repeat (5) frame(6, 40);
        // Destroy the rest of the row.
        repeat (4) begin
            cyc(1'b1, 1'b1, 1'b0, 0);
            cyc(1'b0, 1'b1, 1'b1, 200);
            cyc(1'b0, 1'b1, 1'b1, 360);
            cyc(1'b0, 1'b1, 1'b1, 520);
            cyc(1'b0, 1'b1, 1'b0, 0);
        end
        repeat (2) frame(4, NOHIT);
        // Mid-frame asynchronous reset with damaged shields and a pending hit.
        cyc(1'b0, 1'b1, 1'b1, 40);
        async_reset();

        // Regeneration: damage shield 2 twice, then idle frames.
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0);
        repeat (2) frame(5, 360);
        repeat (5) frame(5, NOHIT);

        // Pending hit discarded by playGame drop.
        frame(5, 200);
        cyc(1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        // Collision coincident with startOfFrame commits at the following frame.
        cyc(1'b1, 1'b1, 1'b1, 200);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0);

        // Randomized traffic, biased toward the shield row.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0,
                    $urandom_range(0, 2) == 0, int'($urandom_range(0, 1200)) - 100);
            end
        end
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0);

        repeat (3) @(posedge clk);
        #5;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shield_bank.md
# shield_bank

Manages a row of `NUM_SHIELDS` destructible bunkers for the game screen. It places each shield at a fixed position and resolves pixel-level collision reports to a shield index. It debounces hits to at most one per shield per frame, tracks per-shield health, and optionally regenerates damaged shields. It sits between the collision detector and the shield drawing/bitmap blocks, replacing the single-shield position block.

## Interface
Parameters:
- `NUM_SHIELDS`, 4: number of shields (1..8).
- `INITIAL_X`, 32: topLeftX of shield 0, in pixels.
- `INITIAL_Y`, 400: topLeftY shared by all shields.
- `SPACING`, 160: X pitch between consecutive shields.
- `SHIELD_WIDTH`, 64: hit span width in pixels. Must be ≤ `SPACING`.
- `MAX_HEALTH`, 4: hits a shield absorbs before it is destroyed.
- `REGEN_FRAMES`, 0: frames between regeneration ticks. 0 disables regeneration.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `startOfFrame`, in, 1: one-cycle pulse at each frame start.
- `playGame`, in, 1: high while a game is running.
- `collision`, in, 1: shield pixel hit by a shot in this cycle.
- `collisionX`, in, 11 signed: screen X of the colliding pixel. Valid only with `collision`.
- `topLeftX`, out, NUM_SHIELDS×11 signed: per-shield top-left X.
- `topLeftY`, out, 11 signed: shared top-left Y.
- `health`, out, NUM_SHIELDS×HW: remaining health per shield, with HW = $clog2(MAX_HEALTH+1).
- `alive`, out, NUM_SHIELDS: 1 when the shield's health is nonzero.
- `allDestroyed`, out, 1: all shields have health 0.
- `hitPulse`, out, 1: one-cycle pulse when any shield lost health at a commit.

## Operation
Positions:
- `topLeftX[i]` = INITIAL_X + i·SPACING. `topLeftY` = INITIAL_Y.
- Both are constant and independent of reset and state.

FSM states IDLE and RUN:
- Reset enters IDLE.
- IDLE→RUN when `playGame`=1 is sampled. RUN→IDLE when `playGame`=0 is sampled.
- In IDLE, every cycle: health = MAX_HEALTH for all shields, pending = 0, regen counter = 0. All collision inputs are ignored.

Hit decode:
- Shield i is hit when `collision`=1 and topLeftX[i] ≤ collisionX < topLeftX[i]+SHIELD_WIDTH.
- Comparisons use 12-bit signed arithmetic, so negative X and the right edge never wrap.
- At most one shield matches, because SHIELD_WIDTH ≤ SPACING. Gaps and off-row X values are ignored.

Per-frame debounce:
- In RUN, a decoded hit sets `pending[i]`. Further hits in the same frame are absorbed.
- Hits on a shield with health 0 are ignored.

Commit, on each `startOfFrame` in RUN:
- For each i with `pending[i]` and health>0, health decrements by 1.
- All `pending` bits clear.
- A collision coincident with `startOfFrame` sets `pending` for the next frame; it is not lost.

Regeneration (REGEN_FRAMES>0):
- The frame counter counts `startOfFrame` pulses 0..REGEN_FRAMES-1 and wraps to 0.
- On the wrap, each shield with 0 < health < MAX_HEALTH and no pending hit at this commit gains 1.
- A destroyed shield (health 0) never regenerates.
- Decrement and regeneration never apply to the same shield at the same commit.

Outputs:
- `alive[i]` = (health[i] ≠ 0). `allDestroyed` = ~|alive.
- Both are combinational from registered health.

## Timing
- Reset values: health = MAX_HEALTH for all, alive = all ones, allDestroyed = 0, hitPulse = 0, pending = 0, counter = 0, state IDLE.
- Hit latency: a collision in cycle t sets `pending` at t+1.
- Health/alive change on the clock edge sampling `startOfFrame`. `hitPulse` is high in the following cycle only.
- `playGame` falling at any point, including mid-frame with pending hits: the next cycle is IDLE, pending hits are discarded, and health is restored.
- `reset` mid-frame takes effect immediately and asynchronously, with no dependency on `clk`.
- Regeneration and decrement apply in the same commit cycle. There is no extra latency.

## Structure
- Package `shield_pkg`:
  - `HEALTH_W` function/localparam.
  - `shield_state_t` enum {IDLE, RUN}.
  - `health_t` typedef.
  - Screen width constants.
- Sub-module `shield_hit_decoder`: combinational. Inputs are collision, collisionX, and position array. Output is a one-hot `hitVec[NUM_SHIELDS]`.
- Top-level `shield_bank` owns the FSM, pending bits, health registers, and regen counter.

## Test plan
All scenarios use default parameters.

- Reset, then `playGame`=1, then 3 frames with no collision → health all 4, alive=4'b1111, topLeftX = {32,192,352,512}, topLeftY=400.
- Collision at X=200 for 40 consecutive cycles in one frame, then `startOfFrame` → health[1]=3, others 4, exactly one `hitPulse`.
- Collisions at X=95, 96, −5 and 600, then commit → health[0]=3. X=96 (gap), −5 and 600 (outside the row) are ignored; only one hitPulse.
- Four frames each containing a hit at X=40 → health[0]=0, alive[0]=0. A fifth hit is ignored and raises no hitPulse. Destroying all four shields gives allDestroyed=1.
- REGEN_FRAMES=2: damage shield 2 to health 2, then idle for 4 frames → health[2]=4 and no higher. A shield at 0 stays at 0.
- Pending hit with `playGame` dropped before `startOfFrame` → health all 4 next cycle, no hitPulse. A collision coincident with `startOfFrame` is committed at the following frame.
